frame_scheduler: RTL
====================

Name: frame_scheduler

Overview:
- Sequences the frame renderer against display timing and owns the double-buffered framebuffer bank selection.
- Derives a game tick from vsync and issues the one-cycle `swap` pulse that starts each new game frame.
- Routes renderer writes to the back bank and flips the displayed bank only at a vsync.
- Latches the player button between frames and handles lose/restart by pulsing the renderer's reset.

Parameters:
- HOR_ACTIVE_PIXELS, 640, display width; used only to size addresses.
- VER_ACTIVE_PIXELS, 480, display height; used only to size addresses.
- FRAME_DIVIDER, 2, vsyncs per game tick (>=1).
- RESTART_HOLDOFF, 30, ticks after lose before a button press may restart.
- Local WR_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; synchronous, active-high
- vsync  in  1  one-cycle pulse at start of vertical blanking
- btn_raw  in  1  asynchronous player button
- render_done  in  1  level; renderer idle and waiting for swap
- lose  in  1  level from renderer; player has lost
- rd_wr_en  in  1  renderer write enable
- rd_wr_addr  in  WR_ADDR_WIDTH  renderer write address
- rd_wr_data  in  1  renderer write pixel
- swap  out  1  one-cycle pulse; starts the next renderer frame
- btn  out  1  button value the renderer uses for the current frame
- game_rst  out  1  one-cycle synchronous reset to the renderer
- fb_wr_en  out  1  framebuffer write enable
- fb_wr_bank  out  1  bank written (always the back bank)
- fb_wr_addr  out  WR_ADDR_WIDTH  framebuffer write address
- fb_wr_data  out  1  framebuffer write pixel
- front_sel  out  1  bank the display reads
- dropped_frames  out  8  saturating count of ticks missed because rendering was not finished

Behaviour:
- Reset values: all outputs 0. front_sel=0, state=INIT, divider count=0, btn latch=0, holdoff count=0.
- btn_raw passes through a 2-FF synchronizer to give btn_sync.
  - btn_latch sets whenever btn_sync=1.
- Tick generation:
  - The divider counts vsync pulses 0..FRAME_DIVIDER-1.
  - tick=1 in the cycle of the vsync that wraps the divider; with FRAME_DIVIDER=1 every vsync is a tick.
  - The divider runs in every state.
- Swap event, raised in the cycle that has tick && render_done && state in {INIT, RUN}:
  - swap<=1 for exactly one cycle; front_sel<=~front_sel.
  - btn<=btn_latch|btn_sync; btn_latch<=0.
  - The new btn value is visible in the same registered cycle as swap.
- btn changes only at a swap event.
- front_sel changes only at swap events, so it is always aligned to vsync.
- Write path, 1-cycle registered:
  - fb_wr_en<=rd_wr_en; fb_wr_bank<=~front_sel (value before any same-cycle toggle).
  - fb_wr_addr<=rd_wr_addr; fb_wr_data<=rd_wr_data.
  - The path is active in all states.
- Dropped frame: tick && !render_done in RUN increments dropped_frames, saturating at 255. front_sel is held and no swap is issued. Ticks in INIT are never counted.
- State machine (RUN and LOST are mutually exclusive):
  - INIT: the first swap event goes to RUN.
  - RUN: lose=1 goes to LOST and clears the holdoff count. A swap event in the same cycle as lose still executes, so the final frame is displayed.
  - LOST: no swaps; each tick increments the holdoff count, saturating at RESTART_HOLDOFF. Once the count equals RESTART_HOLDOFF, a rising edge of btn_sync goes to RESTART.
  - RESTART: game_rst=1 for one cycle; btn_latch<=0, btn<=0; then INIT. front_sel is unchanged.
- rst at any point, including mid-swap or mid-restart, returns every register to its reset value within the same clock.
- lose must be low by the INIT after game_rst; lose seen in INIT is ignored.

Decomposition:
- Package fb_pkg holds:
  - typedef sched_state_t {INIT, RUN, LOST, RESTART}.
  - the addr-width helper function.
  - the shared bank encoding constants FB_BANK_A=0, FB_BANK_B=1.
- Sub-module vsync_tick_divider (vsync, FRAME_DIVIDER → tick) is natural and reusable by other frame-rate consumers.
- The button synchronizer stays inline.

Test Plan:
- Reset, then FRAME_DIVIDER=2 with render_done=1 and vsync every 100 cycles → first swap pulse at the 2nd vsync; front_sel 0→1; state RUN; dropped_frames=0.
- RUN, render_done=0 at four consecutive ticks → no swap, front_sel stable, dropped_frames=4. Raise render_done → swap at the next tick only.
- btn_raw pulsed 1 cycle mid-frame → btn=1 from the next swap, btn=0 after the following swap with no press. btn never changes between swaps.
- Writes at addr 0, 307199 with front_sel=1 → fb_wr_bank=0, addr/data echoed 1 cycle later. Write coincident with a swap → bank equals the pre-swap back bank.
- lose=1 in RUN, RESTART_HOLDOFF=3 → no swaps. A press after 2 ticks is ignored. A press after 3 ticks → one game_rst pulse, then INIT, then a swap on the next tick with render_done.
- rst asserted in LOST with holdoff partially counted → all outputs 0 next cycle; dropped_frames=0; state INIT.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer scheduling blocks:
//   - sched_state_t : game/frame sequencing states
//   - FB_BANK_A/B   : framebuffer bank encoding
//   - fb_addr_width : address width needed to cover one full framebuffer
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        LOST    = 2'd2,
        RESTART = 2'd3
    } sched_state_t;

    localparam logic FB_BANK_A = 1'b0;
    localparam logic FB_BANK_B = 1'b1;

    // Bits needed to address every pixel of an h x v framebuffer.
    function automatic int fb_addr_width(input int h, input int v);
        if (h * v <= 2) begin
            return 1;
        end
        return $clog2(h * v);
    endfunction

endpackage

// File: rtl/vsync_tick_divider.sv
// -----------------------------------------------------------------------------
// vsync_tick_divider
// Divides the vsync pulse train by FRAME_DIVIDER. tick is combinational and
// high in the same cycle as the vsync that wraps the divider, so consumers can
// act on the tick at the exact vsync boundary.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   vsync in  one-cycle pulse at start of vertical blanking
//   tick  out high with every FRAME_DIVIDER-th vsync
// -----------------------------------------------------------------------------
module vsync_tick_divider #(
    parameter int FRAME_DIVIDER = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic tick
);

    localparam int CW = (FRAME_DIVIDER > 1) ? $clog2(FRAME_DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIVIDER - 1);

    logic [CW-1:0] count;

    assign tick = vsync && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (vsync) begin
            // With FRAME_DIVIDER=1, LAST is 0 and the counter never leaves 0.
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
// Sequences the renderer against display timing and owns double-buffered
// bank selection. A game tick (every FRAME_DIVIDER vsyncs) with the renderer
// idle produces a one-cycle swap: the displayed bank flips and the latched
// button is handed to the renderer. Renderer writes are registered and steered
// to the back bank. Losing parks the game until the holdoff has elapsed and a
// fresh button press arrives, which pulses game_rst to the renderer.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   vsync                    one-cycle pulse at start of vertical blanking
//   btn_raw                  asynchronous player button
//   render_done              renderer idle, waiting for swap
//   lose                     renderer reports player has lost
//   rd_wr_en/addr/data       renderer pixel write
//   swap                     one-cycle pulse, starts next renderer frame
//   btn                      button value for the current frame
//   game_rst                 one-cycle reset to the renderer
//   fb_wr_en/bank/addr/data  registered framebuffer write (back bank)
//   front_sel                bank read by the display
//   dropped_frames           saturating count of ticks missed in RUN
// -----------------------------------------------------------------------------
module frame_scheduler
    import fb_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    parameter  int FRAME_DIVIDER     = 2,
    parameter  int RESTART_HOLDOFF   = 30,
    localparam int WR_ADDR_WIDTH     = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vsync,
    input  logic                     btn_raw,
    input  logic                     render_done,
    input  logic                     lose,
    input  logic                     rd_wr_en,
    input  logic [WR_ADDR_WIDTH-1:0] rd_wr_addr,
    input  logic                     rd_wr_data,
    output logic                     swap,
    output logic                     btn,
    output logic                     game_rst,
    output logic                     fb_wr_en,
    output logic                     fb_wr_bank,
    output logic [WR_ADDR_WIDTH-1:0] fb_wr_addr,
    output logic                     fb_wr_data,
    output logic                     front_sel,
    output logic [7:0]               dropped_frames
);

    localparam int HW = (RESTART_HOLDOFF > 0) ? $clog2(RESTART_HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLDOFF_MAX = HW'(RESTART_HOLDOFF);

    sched_state_t  state;
    sched_state_t  next_state;
    logic          tick;
    logic          swap_event;
    logic          btn_meta;
    logic          btn_sync;
    logic          btn_sync_q;
    logic          btn_rise;
    logic          btn_latch;
    logic [HW-1:0] holdoff_cnt;

    vsync_tick_divider #(
        .FRAME_DIVIDER(FRAME_DIVIDER)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .vsync(vsync),
        .tick (tick)
    );

    assign swap_event = tick && render_done && ((state == INIT) || (state == RUN));
    assign btn_rise   = btn_sync && !btn_sync_q;

    // Next-state and game_rst decode.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch cannot be inferred.
        next_state = state;
        game_rst   = 1'b0;
        case (state)
            INIT: begin
                // lose is ignored here; the renderer drops it after game_rst.
                if (swap_event) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (lose) begin
                    next_state = LOST;
                end
            end
            LOST: begin
                if ((holdoff_cnt == HOLDOFF_MAX) && btn_rise) begin
                    next_state = RESTART;
                end
            end
            RESTART: begin
                game_rst   = 1'b1;
                next_state = INIT;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Button synchronizer, latch, swap, bank selection and write path.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchronizer flops are reset too, so a press in flight
            // during rst cannot leak into the first frame afterwards.
            btn_meta       <= 1'b0;
            btn_sync       <= 1'b0;
            btn_sync_q     <= 1'b0;
            btn_latch      <= 1'b0;
            btn            <= 1'b0;
            swap           <= 1'b0;
            front_sel      <= FB_BANK_A;
            fb_wr_en       <= 1'b0;
            fb_wr_bank     <= FB_BANK_A;
            fb_wr_addr     <= '0;
            fb_wr_data     <= 1'b0;
            dropped_frames <= 8'd0;
            holdoff_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every right-hand side
            // (e.g. front_sel feeding fb_wr_bank) is the pre-edge value.
            btn_meta   <= btn_raw;
            btn_sync   <= btn_meta;
            btn_sync_q <= btn_sync;

            swap <= swap_event;

            if (state == RESTART) begin
                btn_latch <= 1'b0;
                btn       <= 1'b0;
            end else if (swap_event) begin
                // A press arriving in the swap cycle itself is not lost.
                btn       <= btn_latch | btn_sync;
                btn_latch <= 1'b0;
            end else if (btn_sync) begin
                btn_latch <= 1'b1;
            end

            if (swap_event) begin
                front_sel <= ~front_sel;
            end

            // Back bank is taken from front_sel before any same-cycle flip.
            fb_wr_en   <= rd_wr_en;
            fb_wr_bank <= ~front_sel;
            fb_wr_addr <= rd_wr_addr;
            fb_wr_data <= rd_wr_data;

            if (tick && !render_done && (state == RUN) && (dropped_frames != 8'hFF)) begin
                dropped_frames <= dropped_frames + 8'd1;
            end

            if ((state == RUN) && (next_state == LOST)) begin
                holdoff_cnt <= '0;
            end else if ((state == LOST) && tick && (holdoff_cnt != HOLDOFF_MAX)) begin
                holdoff_cnt <= holdoff_cnt + HW'(1);
            end
        end
    end

endmodule
